// File: rtl/insight_commit_trace_buf.sv
// Commit-trace capture buffer: round-robin samples per-hart commits into a circular
// buffer under an arm/trigger/stop FSM, then drains oldest-first over valid/ready.
`timescale 1ns/1ps
module insight_commit_trace_buf #(
    parameter int NUM_CH = 2,
    parameter int PC_W   = 40,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int ENT_W = CH_W + PC_W + DATA_W,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic [NUM_CH-1:0]        commit_valid,
    input  logic [NUM_CH*PC_W-1:0]   commit_pc,
    input  logic [NUM_CH*DATA_W-1:0] commit_wdata,
    input  logic                     ctrl_arm,
    input  logic                     ctrl_stop,
    input  logic                     ctrl_wrap,
    input  logic                     trig_en,
    input  logic [PC_W-1:0]          trig_pc,
    input  logic [CNT_W-1:0]         trig_post,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [ENT_W-1:0]         rd_data,
    output logic [1:0]               state,
    output logic                     triggered,
    output logic [CNT_W-1:0]         count,
    output logic [15:0]              drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_POST    = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   post_q, post_d;
    logic [CH_W-1:0]    rr_q, rr_d;
    logic [15:0]        drop_q, drop_d;
    logic               trig_q, trig_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];

    logic               gnt_found;
    logic [CH_W-1:0]    gnt_idx;
    int unsigned        cand;
    logic               trig_hit;
    logic [3:0]         valid_cnt;
    logic               wr_en;
    logic [ENT_W-1:0]   wr_entry;
    logic [3:0]         drop_add;
    logic [16:0]        drop_sum;
    logic               full;
    logic               active;

    // First valid channel at or after the round-robin pointer wins the single write slot.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        trig_hit  = 1'b0;
        valid_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = (int'(rr_q) + i) % NUM_CH;
            if (!gnt_found && commit_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'(cand);
            end
            if (commit_valid[i] && (commit_pc[i*PC_W +: PC_W] == trig_pc)) begin
                trig_hit = 1'b1;
            end
            valid_cnt = valid_cnt + {3'b000, commit_valid[i]};
        end
    end

    assign wr_entry = {gnt_idx,
                       commit_pc[int'(gnt_idx)*PC_W +: PC_W],
                       commit_wdata[int'(gnt_idx)*DATA_W +: DATA_W]};
    assign full     = (count_q == CNT_W'(DEPTH));
    assign active   = (state_q == ST_CAPTURE) || (state_q == ST_POST);
    assign rd_valid = (state_q == ST_DONE) && (count_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        post_d   = post_q;
        rr_d     = rr_q;
        drop_d   = drop_q;
        trig_d   = trig_q;
        wr_en    = 1'b0;
        drop_add = '0;
        drop_sum = '0;
        if (ctrl_arm) begin
            state_d  = ST_CAPTURE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            post_d   = '0;
            rr_d     = '0;
            drop_d   = '0;
            trig_d   = 1'b0;
        end else if (active && ctrl_stop) begin
            state_d = ST_DONE;
        end else if (active) begin
            wr_en    = gnt_found && (!full || ctrl_wrap);
            drop_add = valid_cnt - {3'b000, wr_en};
            drop_sum = {1'b0, drop_q} + {13'd0, drop_add};
            drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                rr_d     = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);
                if (full) begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            if (state_q == ST_CAPTURE && trig_en && trig_hit) begin
                trig_d  = 1'b1;
                post_d  = trig_post;
                state_d = (trig_post == '0) ? ST_DONE : ST_POST;
            end
            if (state_q == ST_POST && wr_en) begin
                post_d = post_q - CNT_W'(1);
                if (post_q == CNT_W'(1)) state_d = ST_DONE;
            end
            // Without wrap, reaching (or sitting at) full ends the capture.
            if (!ctrl_wrap && (full || (wr_en && count_q == CNT_W'(DEPTH - 1)))) begin
                state_d = ST_DONE;
            end
        end else if (rd_valid && rd_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            post_q   <= '0;
            rr_q     <= '0;
            drop_q   <= '0;
            trig_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            post_q   <= post_d;
            rr_q     <= rr_d;
            drop_q   <= drop_d;
            trig_q   <= trig_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
    end

    assign state     = state_q;
    assign triggered = trig_q;
    assign count     = count_q;
    assign drop_cnt  = drop_q;
endmodule
